// File: rtl/sdpram_read_streamer_pkg.sv
// Shared definitions for the block-RAM read streamer: controller states and
// the skid FIFO sizing rule derived from the RAM read latency.
package sdpram_read_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    // Enough slots to hold every word in the RAM pipeline plus one being
    // consumed and one freshly landed, so m_ready=1 sustains full rate.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/sdpram_read_streamer_skid_fifo.sv
// Small synchronous FIFO that absorbs returning RAM words while the consumer
// stalls; exposes occupancy so the issuer can run a credit scheme.
module stream_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdpram_read_streamer.sv
// Read-side controller for a simple dual-port block RAM: issues a contiguous
// burst of reads and returns the words as a valid/ready stream.
module sdpram_read_streamer
    import sdpram_read_streamer_pkg::*;
#(
    parameter int READ_WIDTH      = 8,
    parameter int READ_ADDR_WIDTH = 8,
    parameter int READ_LATENCY_B  = 1,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [READ_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]       num_words,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_enb,
    output logic [READ_ADDR_WIDTH-1:0] mem_addrb,
    output logic                       mem_regceb,
    input  logic [READ_WIDTH-1:0]      mem_doutb,
    output logic                       m_valid,
    output logic [READ_WIDTH-1:0]      m_data,
    output logic                       m_last,
    input  logic                       m_ready
);

    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY_B);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    generate
        if (READ_LATENCY_B < MIN_READ_LATENCY || READ_LATENCY_B > MAX_READ_LATENCY) begin : g_bad_latency
            $error("READ_LATENCY_B must be within 1..4");
        end
    endgenerate

    state_t                     state;
    state_t                     state_next;
    logic [READ_ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]       issue_left;
    logic [LEN_WIDTH-1:0]       out_left;
    logic [READ_LATENCY_B-1:0]  lat_pipe;
    logic [CNT_W-1:0]           inflight;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [READ_WIDTH-1:0]      fifo_head;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       start_ok;
    logic                       credit_ok;
    logic                       issue;
    logic                       last_issue;

    // Stream handshake: a word transfers in any cycle with m_valid & m_ready.
    // m_valid/m_data come straight from the FIFO head, so they hold while
    // stalled and never depend combinationally on m_ready.
    assign m_valid  = !fifo_empty;
    assign m_data   = m_valid ? fifo_head : '0;
    assign m_last   = m_valid && (out_left == LEN_WIDTH'(1));
    assign fifo_pop = m_valid && m_ready;

    // A read is only issued if a FIFO slot is already reserved for its data,
    // which lets the RAM pipeline run without ever being stalled.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign start_ok   = (state == IDLE) && start;
    assign issue      = (state == ISSUE) && credit_ok;
    assign last_issue = issue && (issue_left == LEN_WIDTH'(1));
    assign fifo_push  = lat_pipe[READ_LATENCY_B-1];

    assign mem_enb    = issue;
    assign mem_addrb  = addr;
    assign mem_regceb = reset_n;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (fifo_pop && m_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            issue_left <= '0;
            out_left   <= '0;
            inflight   <= '0;
            lat_pipe   <= '0;
        end else begin
            if (start_ok) begin
                addr       <= base_addr;
                issue_left <= num_words;
                out_left   <= num_words;
            end else begin
                if (issue) begin
                    addr       <= addr + READ_ADDR_WIDTH'(1);
                    issue_left <= issue_left - LEN_WIDTH'(1);
                end
                if (fifo_pop) begin
                    out_left <= out_left - LEN_WIDTH'(1);
                end
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(fifo_push);
            // Issue flag travels alongside the RAM's own read pipeline.
            lat_pipe[0] <= issue;
            for (int i = 1; i < READ_LATENCY_B; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end
        end
    end

    stream_skid_fifo #(
        .WIDTH (READ_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_skid_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (mem_doutb),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_sdpram_read_streamer.sv
// Bench for sdpram_read_streamer: two instances (read latency 1 and 2) share
// stimulus; the selected one is scored against an address/data reference.
module tb_sdpram_read_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [15:0] num_words;
    logic        m_ready;

    logic        busy_a, done_a, enb_a, regceb_a, valid_a, last_a;
    logic [7:0]  addrb_a, data_a, doutb_a;
    logic        busy_b, done_b, enb_b, regceb_b, valid_b, last_b;
    logic [7:0]  addrb_b, data_b, doutb_b;
    logic [7:0]  ram_b_stage;

    logic        s_busy, s_done, s_enb, s_regceb, s_valid, s_last;
    logic [7:0]  s_addrb, s_data;

    logic [7:0]  mem [256];
    logic [8:0]  exp_q[$];
    logic [7:0]  addr_q[$];

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          cur = 0;
    int          ready_mode = 0;
    int          rdy_idx = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    int          issued, hs_cnt, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    logic        busy_at_done;
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdpram_read_streamer #(
        .READ_WIDTH(8), .READ_ADDR_WIDTH(8), .READ_LATENCY_B(1), .LEN_WIDTH(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy_a), .done(done_a), .mem_enb(enb_a),
        .mem_addrb(addrb_a), .mem_regceb(regceb_a), .mem_doutb(doutb_a),
        .m_valid(valid_a), .m_data(data_a), .m_last(last_a), .m_ready(m_ready)
    );

    sdpram_read_streamer #(
        .READ_WIDTH(8), .READ_ADDR_WIDTH(8), .READ_LATENCY_B(2), .LEN_WIDTH(16)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy_b), .done(done_b), .mem_enb(enb_b),
        .mem_addrb(addrb_b), .mem_regceb(regceb_b), .mem_doutb(doutb_b),
        .m_valid(valid_b), .m_data(data_b), .m_last(last_b), .m_ready(m_ready)
    );

    // Block-RAM read ports: latency 1 without, latency 2 with output register.
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    always @(posedge clk) if (enb_a) doutb_a <= mem[addrb_a];
    always @(posedge clk) begin
        if (enb_b) ram_b_stage <= mem[addrb_b];
        if (regceb_b) doutb_b <= ram_b_stage;
    end

    always_comb begin
        if (cur == 1) begin
            s_busy = busy_b; s_done = done_b; s_enb = enb_b; s_regceb = regceb_b;
            s_valid = valid_b; s_last = last_b; s_addrb = addrb_b; s_data = data_b;
        end else begin
            s_busy = busy_a; s_done = done_a; s_enb = enb_a; s_regceb = regceb_a;
            s_valid = valid_a; s_last = last_a; s_addrb = addrb_a; s_data = data_a;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0d, expected no such event (cycle %0d)", name, act, cyc);
    endtask

    // Consumer readiness patterns: always ready, 1-0-0-1, or random.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = rdy_pat[rdy_idx % 4];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            rdy_idx++;
        end
    end

    // Monitor: scores every issued read and every transferred word.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(s_valid), 32'd1);
                check("hold_data", 32'(s_data), 32'(data_prev));
            end
            if (s_enb) begin
                issued++;
                check("credit_bound", 32'(issued - hs_cnt <= cur + 3), 32'd1);
                if (addr_q.size() == 0) fail_now("unexpected_read", int'(s_addrb));
                else check("read_addr", 32'(s_addrb), 32'(addr_q.pop_front()));
            end
            if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_valid && m_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_word", int'(s_data));
                else check("word_last_data", 32'({s_last, s_data}), 32'(exp_q.pop_front()));
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
            end
            if (s_done && done_cyc < 0) begin
                done_cyc = cyc;
                busy_at_done = s_busy;
            end
            stall_prev = s_valid && !m_ready;
            data_prev = s_data;
        end
    end

    task automatic clear_tracking();
        issued = 0; hs_cnt = 0; first_valid_cyc = -1; first_hs_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        check("rst_enb", 32'(s_enb), 32'd0);
        check("rst_addrb", 32'(s_addrb), 32'd0);
        check("rst_regceb", 32'(s_regceb), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_last", 32'(s_last), 32'd0);
        check("rst_data", 32'(s_data), 32'd0);
    endtask

    task automatic push_expected(input logic [7:0] base, input int len);
        logic [7:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            exp_q.push_back({i == len - 1, mem[a]});
            addr_q.push_back(a);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after done.
    task automatic run_xfer(input logic [7:0] base, input int len, input int rmode, input bit dbl);
        int t0;
        int k;
        ready_mode = rmode;
        push_expected(base, len);
        clear_tracking();
        start = 1'b1; base_addr = base; num_words = 16'(len); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); num_words = 16'($urandom_range(1, 20));
        check("busy_t1", 32'(s_busy), 32'(len != 0));
        check("enb_t1", 32'(s_enb), 32'(len != 0));
        if (dbl) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; base_addr = 8'hA0; num_words = 16'd9;
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (done_cyc < 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cyc < 0) begin
            fail_now("done_timeout", k);
            exp_q.delete();
            addr_q.delete();
        end else begin
            check("done_cycle", 32'(done_cyc), 32'((len == 0) ? t0 + 1 : last_hs_cyc + 1));
            check("busy_at_done", 32'(busy_at_done), 32'd0);
            check("words_left", 32'(exp_q.size()), 32'd0);
            check("reads_issued", 32'(issued), 32'(len));
            check("done_pulse_width", 32'(s_done), 32'd0);
            if (len > 0) check("first_valid", 32'(first_valid_cyc), 32'(t0 + 2 + cur + 1));
            if (len > 0 && rmode == 0) check("throughput", 32'(last_hs_cyc - first_hs_cyc), 32'(len - 1));
        end
    endtask

    task automatic reset_mid_transfer();
        int k;
        ready_mode = 0;
        push_expected(8'h30, 6);
        clear_tracking();
        start = 1'b1; base_addr = 8'h30; num_words = 16'd6;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs_cnt < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        addr_q.delete();
        done_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_reset", 32'(done_cyc), 32'hFFFF_FFFF);
        check("words_before_reset", 32'(hs_cnt), 32'd2);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        clear_tracking();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        #1;
        check("regceb_out_of_reset", 32'(s_regceb), 32'd1);
        @(posedge clk); #1;

        run_xfer(8'h10, 4, 0, 1'b0);
        run_xfer(8'h20, 8, 1, 1'b0);
        run_xfer(8'hFE, 4, 0, 1'b0);
        run_xfer(8'h33, 0, 0, 1'b0);
        run_xfer(8'h50, 4, 1, 1'b1);
        reset_mid_transfer();
        run_xfer(8'h40, 2, 0, 1'b0);
        repeat (25) run_xfer(8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'b0);

        // Re-align both instances, then score the latency-2 one.
        reset_n = 1'b0;
        @(posedge clk); #1;
        cur = 1;
        exp_q.delete();
        addr_q.delete();
        check_reset_outputs();
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(8'h10, 4, 0, 1'b0);
        repeat (12) run_xfer(8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sdpram_read_streamer.md
# sdpram_read_streamer

Read-side controller for the simple dual-port block-RAM wrappers. On a start command it drives the read port (enb, addrb, regceb) over a contiguous address range and tracks the RAM's fixed read latency. It presents the returned words as a valid/ready stream with full backpressure and no lost or duplicated words. It sits between a buffer's read port and the consumer, such as the systolic array feeder or the output DMA.

## Interface
- READ_WIDTH, 8, data word width; must match the RAM's read width
- READ_ADDR_WIDTH, 8, RAM read address width
- READ_LATENCY_B, 1, RAM read latency in cycles; legal range 1..4
- LEN_WIDTH, 16, width of the word-count field
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only while idle
- base_addr  in  READ_ADDR_WIDTH  first read address; sampled when start is accepted
- num_words  in  LEN_WIDTH  number of words to read; sampled when start is accepted
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the transfer completes
- mem_enb  out  1  RAM read enable; one read is issued per cycle in which it is high
- mem_addrb  out  READ_ADDR_WIDTH  RAM read address
- mem_regceb  out  1  RAM output-register clock enable
- mem_doutb  in  READ_WIDTH  RAM read data
- m_valid  out  1  stream data valid
- m_data  out  READ_WIDTH  stream data
- m_last  out  1  marks the final word of the transfer; qualified by m_valid
- m_ready  in  1  consumer ready

## Operation
- States:
  - IDLE: start accepted → ISSUE, or → DONE if num_words == 0.
  - ISSUE: last read issued → DRAIN.
  - DRAIN: final word handshaked (m_valid & m_ready with m_last) → DONE.
  - DONE: one cycle, done=1 → IDLE.
- start in any state other than IDLE is ignored. Base, length and mode are never disturbed mid-transfer.
- Issue rule: mem_enb=1 in ISSUE when inflight + fifo_count < FIFO_DEPTH, where FIFO_DEPTH = READ_LATENCY_B + 2.
  - inflight counts reads issued whose data has not yet returned.
  - mem_addrb increments after each issue, modulo 2^READ_ADDR_WIDTH. The address wraps with no error.
- Latency tracking: a READ_LATENCY_B-deep shift register carries the issue flag. When it emerges, mem_doutb is written into the skid FIFO.
- The credit rule guarantees the FIFO never overflows. An overflow is a design bug; flag it with an assertion.
- m_data and m_valid come from the FIFO head. m_last=1 when the head is word num_words-1, tracked by a remaining-words down-counter.
- mem_regceb=1 whenever reset_n=1. The RAM pipeline is never stalled; all backpressure is absorbed by credits.
- Reset values: busy=0, done=0, mem_enb=0, mem_addrb=0, mem_regceb=0, m_valid=0, m_last=0, m_data=0. inflight=0, FIFO empty.
- Reset asserted mid-transfer: all state clears immediately. Data from in-flight reads returning after reset is discarded. No done pulse is produced.

## Timing
- start accepted at cycle T → first mem_enb at T+1 with mem_addrb=base_addr.
- Read data is captured into the FIFO at T+1+READ_LATENCY_B. First m_valid at T+2+READ_LATENCY_B.
- With m_ready held high: one word per cycle sustained and one read issued per cycle.
- m_ready low: issue stops once credits reach FIFO_DEPTH. Issue resumes the cycle after a handshake frees a slot.
- Valid/ready rule: m_valid and m_data stay stable while m_valid=1 and m_ready=0. m_valid never depends combinationally on m_ready.
- done and busy=0 occur in the cycle after the final handshake.
- num_words=0: done at T+1, no mem_enb, no m_valid.
- A new start is accepted the cycle after done, i.e. when back in IDLE.

## Structure
- Shared package: the state enum (IDLE, ISSUE, DRAIN, DONE) and the function computing FIFO_DEPTH from the latency.
- One sub-module, stream_skid_fifo: a synchronous FIFO with parameterised width and depth, exposing count, full and empty.
- Latency shift register, credit counter and address counter stay in the top module.

## Test plan
- Setup for all cases: READ_LATENCY_B=1, 8-bit words, RAM preloaded with data = address.
- Basic: base 0x10, 4 words, m_ready=1 → m_data 0x10, 0x11, 0x12, 0x13 on consecutive cycles; m_last on 0x13; done one cycle later.
- Backpressure: base 0x20, 8 words, m_ready toggling 1-0-0-1 → all 8 words in order, no drops or duplicates; inflight + fifo_count never exceeds 3.
- Wrap: base 0xFE, 4 words → addresses 0xFE, 0xFF, 0x00, 0x01; m_data identical to those addresses.
- Zero length and busy start: num_words=0 → done at T+1 with no mem_enb. Second start during a 4-word transfer → ignored; exactly 4 words emitted.
- Reset mid-transfer: reset_n low after 2 of 6 words → all outputs at reset values. No done pulse. The next start at base 0x40 for 2 words yields 0x40, 0x41.
- Latency sweep: repeat the Basic case at READ_LATENCY_B=2 → first m_valid at T+4; throughput one word per cycle.
